// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM state and access owner.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OWNER_CPU  = 1'b0,
      OWNER_HOST = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arbiter_arb2_rr.sv
// Two-requester round-robin pick: a lone requester always wins, a tie goes to
// whichever side was not granted last.
module arb2_rr
   import mem_arbiter_pkg::*;
(
   input  logic req_cpu_i,
   input  logic req_host_i,
   input  logic last_owner_i,
   output logic grant_host_o
);

   assign grant_host_o = req_host_i & (~req_cpu_i | (last_owner_i == OWNER_CPU));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the external memory port between the CPU and the host loader port.
// IDLE latches the winning request, ACCESS waits for mem_ack, DONE pulses done.
//
// Handshake: a requester raises req and holds req and operands stable until it
// sees its done pulse; mem_req stays high in ACCESS until mem_ack, which may be
// combinational from mem_req; mem_rdata is taken on the mem_ack edge.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_done,
   output logic                  cpu_stall,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  host_done,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy,
   output logic [1:0]            dbg_state_o
);

   state_e                state_q, state_d;
   owner_e                owner_q, owner_d;
   owner_e                last_owner_q, last_owner_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
   logic                  grant_host;

   arb2_rr u_arb (
      .req_cpu_i    (cpu_req),
      .req_host_i   (host_req),
      .last_owner_i (last_owner_q),
      .grant_host_o (grant_host)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWNER_CPU;
         last_owner_q <= OWNER_HOST;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cpu_rdata_q  <= '0;
         host_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         host_rdata_q <= host_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      host_rdata_d = host_rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cpu_req || host_req) begin
               state_d = ST_ACCESS;
               if (grant_host) begin
                  owner_d      = OWNER_HOST;
                  last_owner_d = OWNER_HOST;
                  we_d         = host_we;
                  addr_d       = host_addr;
                  wdata_d      = host_wdata;
               end else begin
                  owner_d      = OWNER_CPU;
                  last_owner_d = OWNER_CPU;
                  we_d         = cpu_we;
                  addr_d       = cpu_addr;
                  wdata_d      = cpu_wdata;
               end
            end
         end
         ST_ACCESS: begin
            if (mem_ack) begin
               state_d = ST_DONE;
               // Writes leave the owner's read register untouched.
               if (!we_q) begin
                  if (owner_q == OWNER_HOST) host_rdata_d = mem_rdata;
                  else                       cpu_rdata_d  = mem_rdata;
               end
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign mem_req     = (state_q == ST_ACCESS);
   assign mem_we      = mem_req & we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign cpu_done    = (state_q == ST_DONE) && (owner_q == OWNER_CPU);
   assign host_done   = (state_q == ST_DONE) && (owner_q == OWNER_HOST);
   assign cpu_stall   = cpu_req & ~cpu_done;
   assign cpu_rdata   = cpu_rdata_q;
   assign host_rdata  = host_rdata_q;
   assign busy        = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;

endmodule
